// File: rtl/pipe_reg_pkg.sv
// Shared helpers for the elastic pipeline register.
// Only width-independent items live here; the data width stays a module parameter.
package pipe_reg_pkg;

  // Bits needed to count 0..depth valid stages inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data word.
// The valid bit follows its source whenever the stage is allowed to load.
// The data word captures only real items, so it keeps its last value when the stage empties.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid bit: flush wins over any transfer; otherwise take the upstream valid on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= src_valid;
    end
  end

  // Data word: capture only when a real item moves in. Flush leaves the contents alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (!flush && load && src_valid) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/pipe_reg_n.sv
// DEPTH-stage elastic pipeline register with valid/ready on both sides.
// An empty stage always accepts its upstream neighbour, so bubbles close up even
// while the output is stalled. The ready chain runs combinationally from out_ready
// back to in_ready through DEPTH OR stages; that path is intentional.
module pipe_reg_n
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   occupancy
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  // ready_c[k] means stage k may load this cycle; ready_c[DEPTH] is the downstream ready.
  logic [DEPTH:0]              ready_c;
  logic [CW-1:0]               occ_c;

  assign ready_c[DEPTH] = out_ready;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      // A stage can load when it is empty or its occupant is moving on.
      assign ready_c[k] = !valid_q[k] || ready_c[k+1];

      if (k == 0) begin : g_head
        // Input offered during a flush is refused, so it never enters stage 0.
        assign src_valid = in_valid && !flush;
        assign src_data  = in_data;
      end else begin : g_body
        assign src_valid = valid_q[k-1];
        assign src_data  = data_q[k-1];
      end

      pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (ready_c[k]),
        .src_valid (src_valid),
        .src_data  (src_data),
        .valid     (valid_q[k]),
        .data      (data_q[k])
      );
    end
  endgenerate

  // Occupancy is a plain popcount of the stage valid bits.
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_c = occ_c + CW'(valid_q[i]);
    end
  end

  assign in_ready  = ready_c[0] && !flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_c;

endmodule
